// File: rtl/bcd_conv_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package bcd_conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DIGIT_W  = 4;
  localparam int unsigned ADD3_TH  = 5;

  // Decimal digits needed to hold 2^bin_w - 1 without overflow.
  function automatic int unsigned min_digits(input int unsigned bin_w);
    longint unsigned v;
    int unsigned n;
    v = (64'd1 << bin_w) - 64'd1;
    n = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_converter_n_if.sv
// Handshake bus between a producer of binary values and the BCD converter.
interface bcd_converter_n_if
  import bcd_conv_pkg::*;
#(
  parameter int unsigned BIN_W  = 16,
  parameter int unsigned DIGITS = 5
);
  logic                      IN_VALID;
  logic                      IN_READY;
  logic [BIN_W-1:0]          BIN;
  logic                      OUT_VALID;
  logic                      OUT_READY;
  logic [DIGIT_W*DIGITS-1:0] BCDOUT;
  logic                      OVF;
  logic                      SIGN;
  logic                      BUSY;

  modport master (
    output IN_VALID, BIN, OUT_READY,
    input  IN_READY, OUT_VALID, BCDOUT, OVF, SIGN, BUSY
  );

  modport slave (
    input  IN_VALID, BIN, OUT_READY,
    output IN_READY, OUT_VALID, BCDOUT, OVF, SIGN, BUSY
  );
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj
  import bcd_conv_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);
  assign dout = (din >= DIGIT_W'(ADD3_TH)) ? din + DIGIT_W'(3) : din;
endmodule

// File: rtl/bcd_converter_n.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per cycle).
// Optional two's-complement input when BCD_CONV_SIGNED_EN is defined.
module bcd_converter_n
  import bcd_conv_pkg::*;
#(
  parameter int unsigned BIN_W  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic              CLK,
  input  logic              RST,
  bcd_converter_n_if.slave  bus
);
  localparam int unsigned BCD_W = DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  if (BIN_W < 4 || BIN_W > 32 || DIGITS < 1 || DIGITS > 10) begin : g_param_check
    $error("bcd_converter_n: BIN_W must be 4..32 and DIGITS 1..10");
  end

  state_t             state, state_n;
  logic [BCD_W-1:0]   bcd_q, bcd_adj;
  logic [BIN_W-1:0]   bin_q, mag;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_acc_q, sign_acc_q, sign_in;
  logic [BCD_W-1:0]   bcdout_q;
  logic               ovf_q, sign_q, out_valid_q, in_ready_q, busy_q;
  logic               accept, last_step;

  assign accept    = bus.IN_VALID && in_ready_q;
  assign last_step = (cnt_q == CNT_W'(BIN_W));

`ifdef BCD_CONV_SIGNED_EN
  assign sign_in = bus.BIN[BIN_W-1];
  assign mag     = sign_in ? BIN_W'(-bus.BIN) : bus.BIN;
`else
  assign sign_in = 1'b0;
  assign mag     = bus.BIN;
`endif

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (bcd_q  [i*DIGIT_W +: DIGIT_W]),
      .dout (bcd_adj[i*DIGIT_W +: DIGIT_W])
    );
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept)        state_n = CONV;
      CONV:    if (last_step)     state_n = DONE;
      DONE:    if (bus.OUT_READY) state_n = IDLE;
      default:                    state_n = IDLE;
    endcase
  end

  // Shift register, counter and result registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      bcd_q      <= '0;
      bin_q      <= '0;
      cnt_q      <= '0;
      ovf_acc_q  <= 1'b0;
      sign_acc_q <= 1'b0;
      bcdout_q   <= '0;
      ovf_q      <= 1'b0;
      sign_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          bin_q      <= mag;
          bcd_q      <= '0;
          cnt_q      <= '0;
          ovf_acc_q  <= 1'b0;
          sign_acc_q <= sign_in;
        end
        CONV: if (!last_step) begin
          // Top bit of the corrected field leaves the register: weight 10^DIGITS.
          bcd_q     <= {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
          bin_q     <= {bin_q[BIN_W-2:0], 1'b0};
          cnt_q     <= cnt_q + CNT_W'(1);
          ovf_acc_q <= ovf_acc_q | bcd_adj[BCD_W-1];
        end else begin
          bcdout_q <= bcd_q;
          ovf_q    <= ovf_acc_q;
          sign_q   <= sign_acc_q;
        end
        default: ;
      endcase
    end
  end

  // Registered status flags decoded from the next state
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      out_valid_q <= (state_n == DONE);
      in_ready_q  <= (state_n == IDLE);
      busy_q      <= (state_n != IDLE);
    end
  end

  assign bus.IN_READY  = in_ready_q;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.BCDOUT    = bcdout_q;
  assign bus.OVF       = ovf_q;
  assign bus.SIGN      = sign_q;
  assign bus.BUSY      = busy_q;

endmodule

// File: tb/tb_bcd_converter_n.sv
// Directed bench: a 5-digit and a 4-digit converter driven in lockstep.
module tb_bcd_converter_n;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  bcd_converter_n_if #(.BIN_W(16), .DIGITS(5)) if5 ();
  bcd_converter_n_if #(.BIN_W(16), .DIGITS(4)) if4 ();

  assign if4.IN_VALID  = if5.IN_VALID;
  assign if4.BIN       = if5.BIN;
  assign if4.OUT_READY = if5.OUT_READY;

  bcd_converter_n #(.BIN_W(16), .DIGITS(5)) dut5 (.CLK(CLK), .RST(RST), .bus(if5));
  bcd_converter_n #(.BIN_W(16), .DIGITS(4)) dut4 (.CLK(CLK), .RST(RST), .bus(if4));

  typedef struct {
    logic [15:0] bin;
    logic [19:0] bcd5;
    logic        ovf5;
    logic        sign;
    logic [15:0] bcd4;
    logic        ovf4;
  } vec_t;

  localparam int NVEC = 13;
  vec_t tbl [NVEC];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Wait for IN_READY, present one value, return cycles from accept edge to OUT_VALID.
  task automatic convert(input logic [15:0] b, output int lat);
    int guard = 0;
    while (!if5.IN_READY && guard < 100) begin
      tick();
      guard++;
    end
    chk("ready_wait", 64'(guard < 100), 64'd1);
    if5.IN_VALID = 1'b1;
    if5.BIN      = b;
    tick();
    if5.IN_VALID = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!if5.OUT_VALID && lat < 100);
  endtask

  task automatic release_out();
    if5.OUT_READY = 1'b1;
    tick();
    if5.OUT_READY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    tbl[0]  = '{16'd0,     20'h00000, 1'b0, 1'b0, 16'h0000, 1'b0};
    tbl[1]  = '{16'd1,     20'h00001, 1'b0, 1'b0, 16'h0001, 1'b0};
    tbl[2]  = '{16'd9,     20'h00009, 1'b0, 1'b0, 16'h0009, 1'b0};
    tbl[3]  = '{16'd10,    20'h00010, 1'b0, 1'b0, 16'h0010, 1'b0};
    tbl[4]  = '{16'd99,    20'h00099, 1'b0, 1'b0, 16'h0099, 1'b0};
    tbl[5]  = '{16'd255,   20'h00255, 1'b0, 1'b0, 16'h0255, 1'b0};
    tbl[6]  = '{16'd1000,  20'h01000, 1'b0, 1'b0, 16'h1000, 1'b0};
    tbl[7]  = '{16'd9999,  20'h09999, 1'b0, 1'b0, 16'h9999, 1'b0};
    tbl[8]  = '{16'd10000, 20'h10000, 1'b0, 1'b0, 16'h0000, 1'b1};
    tbl[9]  = '{16'd12345, 20'h12345, 1'b0, 1'b0, 16'h2345, 1'b1};
`ifdef BCD_CONV_SIGNED_EN
    tbl[10] = '{16'd59999, 20'h05537, 1'b0, 1'b1, 16'h5537, 1'b0};
    tbl[11] = '{16'h8000,  20'h32768, 1'b0, 1'b1, 16'h2768, 1'b1};
    tbl[12] = '{16'hFFFF,  20'h00001, 1'b0, 1'b1, 16'h0001, 1'b0};
`else
    tbl[10] = '{16'd59999, 20'h59999, 1'b0, 1'b0, 16'h9999, 1'b1};
    tbl[11] = '{16'h8000,  20'h32768, 1'b0, 1'b0, 16'h2768, 1'b1};
    tbl[12] = '{16'hFFFF,  20'h65535, 1'b0, 1'b0, 16'h5535, 1'b1};
`endif

    RST           = 1'b1;
    if5.IN_VALID  = 1'b0;
    if5.BIN       = 16'h0;
    if5.OUT_READY = 1'b0;
    repeat (3) tick();
    RST = 1'b0;
    tick();

    chk("rst_bcdout",    64'(if5.BCDOUT),    64'h0);
    chk("rst_ovf",       64'(if5.OVF),       64'd0);
    chk("rst_sign",      64'(if5.SIGN),      64'd0);
    chk("rst_out_valid", 64'(if5.OUT_VALID), 64'd0);
    chk("rst_busy",      64'(if5.BUSY),      64'd0);
    chk("rst_in_ready",  64'(if5.IN_READY),  64'd1);

    // Table of single conversions on both widths
    for (int i = 0; i < NVEC; i++) begin
      convert(tbl[i].bin, lat);
      chk($sformatf("v%0d_latency", i),  64'(lat),           64'd17);
      chk($sformatf("v%0d_bcd5", i),     64'(if5.BCDOUT),    64'(tbl[i].bcd5));
      chk($sformatf("v%0d_ovf5", i),     64'(if5.OVF),       64'(tbl[i].ovf5));
      chk($sformatf("v%0d_sign5", i),    64'(if5.SIGN),      64'(tbl[i].sign));
      chk($sformatf("v%0d_valid4", i),   64'(if4.OUT_VALID), 64'd1);
      chk($sformatf("v%0d_bcd4", i),     64'(if4.BCDOUT),    64'(tbl[i].bcd4));
      chk($sformatf("v%0d_ovf4", i),     64'(if4.OVF),       64'(tbl[i].ovf4));
      chk($sformatf("v%0d_in_ready_done", i), 64'(if5.IN_READY), 64'd0);
      release_out();
      chk($sformatf("v%0d_valid_after", i), 64'(if5.OUT_VALID), 64'd0);
      chk($sformatf("v%0d_bcd_kept", i),    64'(if5.BCDOUT),    64'(tbl[i].bcd5));
    end

    // Consumer stalls in DONE while a new input is offered
    convert(16'd4321, lat);
    chk("hold_latency", 64'(lat), 64'd17);
    for (int c = 0; c < 10; c++) begin
      if5.IN_VALID = 1'b1;
      if5.BIN      = 16'd7;
      tick();
      chk($sformatf("hold%0d_valid", c),    64'(if5.OUT_VALID), 64'd1);
      chk($sformatf("hold%0d_bcd", c),      64'(if5.BCDOUT),    64'h04321);
      chk($sformatf("hold%0d_in_ready", c), 64'(if5.IN_READY),  64'd0);
    end
    if5.IN_VALID = 1'b0;
    release_out();
    chk("hold_exit_valid",    64'(if5.OUT_VALID), 64'd0);
    chk("hold_exit_bcd",      64'(if5.BCDOUT),    64'h04321);
    chk("hold_exit_in_ready", 64'(if5.IN_READY),  64'd1);
    repeat (3) tick();
    chk("hold_no_queue_busy", 64'(if5.BUSY), 64'd0);

    // Reset in the middle of a conversion
    if5.IN_VALID = 1'b1;
    if5.BIN      = 16'hFFFF;
    tick();
    if5.IN_VALID = 1'b0;
    repeat (7) tick();
    chk("midrst_busy_before", 64'(if5.BUSY), 64'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("midrst_out_valid", 64'(if5.OUT_VALID), 64'd0);
    chk("midrst_bcd5",      64'(if5.BCDOUT),    64'h0);
    chk("midrst_bcd4",      64'(if4.BCDOUT),    64'h0);
    chk("midrst_busy",      64'(if5.BUSY),      64'd0);
    chk("midrst_in_ready",  64'(if5.IN_READY),  64'd1);
    convert(16'd42, lat);
    chk("midrst_next_latency", 64'(lat),        64'd17);
    chk("midrst_next_bcd",     64'(if5.BCDOUT), 64'h00042);
    chk("midrst_next_ovf",     64'(if5.OVF),    64'd0);
    release_out();

    // Back-to-back stream with both sides always willing
    begin
      int cyc = 0, last = -1, n = 0, viol = 0;
      if5.BIN       = 16'd300;
      if5.IN_VALID  = 1'b1;
      if5.OUT_READY = 1'b1;
      while (n < 3 && cyc < 200) begin
        tick();
        cyc++;
        if (if5.IN_READY && if5.BUSY) viol++;
        if (if5.OUT_VALID) begin
          chk($sformatf("b2b%0d_bcd", n), 64'(if5.BCDOUT), 64'h00300);
          if (last >= 0) chk($sformatf("b2b%0d_period", n), 64'(cyc - last), 64'd19);
          last = cyc;
          n++;
          tick();
          cyc++;
          chk($sformatf("b2b%0d_ready_after_done", n), 64'(if5.IN_READY), 64'd1);
        end
      end
      if5.IN_VALID  = 1'b0;
      if5.OUT_READY = 1'b0;
      chk("b2b_count",            64'(n),    64'd3);
      chk("b2b_ready_during_conv", 64'(viol), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_converter_n.md
BCD_CONVERTER_N -- requirements
Module: bcd_converter_n

Interface
REQ-001 Parameter BIN_W, default 16: binary input width; legal range 4..32.
REQ-002 Parameter DIGITS, default 5: number of BCD output digits; legal range 1..10.
REQ-003 Port CLK, input, 1: system clock; all state changes on the rising edge.
REQ-004 Port RST, input, 1: reset, synchronous, active-high.
REQ-005 Port IN_VALID, input, 1: BIN carries a value to convert.
REQ-006 Port IN_READY, output, 1: converter can accept a value.
REQ-007 Port BIN, input, BIN_W: binary value; sampled only on an accept.
REQ-008 Port OUT_VALID, output, 1: result available on BCDOUT/OVF/SIGN.
REQ-009 Port OUT_READY, input, 1: consumer takes the result.
REQ-010 Port BCDOUT, output, 4*DIGITS: packed BCD; digit 0 (ones) in bits [3:0].
REQ-011 Port OVF, output, 1: value did not fit in DIGITS digits.
REQ-012 Port SIGN, output, 1: result is negative.
REQ-013 Port BUSY, output, 1: high in every state other than IDLE.

Function
REQ-014 The FSM SHALL use states IDLE, CONV and DONE.
REQ-015 IN_READY SHALL be 1 only in IDLE.
- Accept is IN_VALID&&IN_READY.
- On accept: load the magnitude into the shift register, clear the BCD field, OVF and the shift counter, and go to CONV.
REQ-016 Each CONV cycle SHALL perform one combined step:
- add 3 to every digit that is >=5;
- shift the whole register left 1 bit;
- increment the counter.
REQ-017 After exactly BIN_W CONV cycles the FSM SHALL enter DONE and register BCDOUT, OVF and SIGN. OUT_VALID rises BIN_W+1 cycles after the accept edge.
REQ-018 OVF SHALL be set if any 1 bit is shifted out of the top digit during conversion. In that case BCDOUT holds the value modulo 10^DIGITS.
REQ-019 In DONE, OUT_VALID SHALL stay 1 and BCDOUT/OVF/SIGN SHALL stay stable until OUT_READY=1. The FSM then returns to IDLE on that edge.
REQ-020 BCDOUT, OVF and SIGN SHALL keep their last values after leaving DONE; OUT_VALID SHALL then be 0.
REQ-021 IN_VALID while not in IDLE SHALL be ignored. No queueing; the input is not sampled.
REQ-022 Input 0 SHALL produce all-zero BCDOUT, OVF=0 and SIGN=0.
REQ-023 An all-ones BIN SHALL convert correctly without counter wrap. The counter width is clog2(BIN_W+1).

Reset
REQ-024 RST SHALL force, from any state including mid-CONV or DONE:
- state IDLE;
- BCDOUT=0, OVF=0, SIGN=0, OUT_VALID=0, BUSY=0;
- shift register and counter cleared.
The in-flight conversion is discarded.
REQ-025 IN_READY SHALL be 1 in the first cycle after RST deasserts.

Configuration
REQ-026 Macro BCD_CONV_SIGNED_EN defined:
- BIN is two's complement;
- magnitude = |BIN| as a BIN_W-bit unsigned value, so -2^(BIN_W-1) converts correctly;
- SIGN = BIN[BIN_W-1], captured at accept.
REQ-027 Macro BCD_CONV_SIGNED_EN undefined:
- BIN is unsigned;
- SIGN is constant 0;
- no negation logic is present.

Structure
REQ-028 Package bcd_conv_pkg SHALL hold:
- the FSM state enum (IDLE, CONV, DONE);
- the BCD digit width constant 4;
- the add-3 threshold constant 5;
- a function giving the minimum DIGITS for a given BIN_W.
REQ-029 Sub-module bcd_digit_adj SHALL implement the 4-bit conditional add-3. It is instantiated DIGITS times.
REQ-030 An elaboration check SHALL reject illegal BIN_W/DIGITS values.

Verification
REQ-031 BIN_W=16, DIGITS=5, BIN=0xFFFF -> BCDOUT=0x65535, OVF=0, OUT_VALID at the 17th cycle after accept.
REQ-032 BIN_W=16, DIGITS=4, BIN=12345 -> BCDOUT=0x2345, OVF=1.
REQ-033 OUT_READY held 0 for 10 cycles in DONE -> OUT_VALID=1 and BCDOUT stable throughout; IN_READY=0; a new IN_VALID is ignored.
REQ-034 RST pulsed at CONV cycle 8 -> next cycle IDLE, OUT_VALID=0, BCDOUT=0; the next accept of BIN=42 -> BCDOUT=0x00042.
REQ-035 BCD_CONV_SIGNED_EN defined, BIN=0xFFFF -> SIGN=1, BCDOUT=0x00001; BIN=0x8000 -> SIGN=1, BCDOUT=0x32768.
REQ-036 Back-to-back operation: IN_VALID held high with OUT_READY=1 -> a new accept in the cycle after each DONE exit; IN_READY never high during CONV.
